// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer FIFOs (ALU, LSB) drained
// round-robin onto a registered single-result broadcast bus.

module cdb_arbiter_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Entry storage; written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry and occupancy flags straight from current state.
  always_comb begin
    rdata = mem[rd_ptr];
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
  end

endmodule

module cdb_arbiter #(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_full,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_full,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src,
  output logic                overflow
);

  localparam int unsigned ENTRY_W = ROB_ID_W + DATA_W;
  localparam logic        SRC_ALU = 1'b0;
  localparam logic        SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_entry_t;

  cdb_entry_t alu_in;
  cdb_entry_t lsb_in;
  cdb_entry_t alu_head;
  cdb_entry_t lsb_head;
  cdb_entry_t grant_entry;

  logic alu_empty;
  logic lsb_empty;
  logic normal;
  logic flush;
  logic alu_push;
  logic lsb_push;
  logic alu_pop;
  logic lsb_pop;
  logic grant_any;
  logic grant_src;
  logic drop;
  logic rr_last;

  // Edge qualification: flush only when enabled, normal work otherwise.
  always_comb begin
    flush    = rdy && clear;
    normal   = rdy && !clear;
    alu_in   = '{rob_id: alu_rob_id, value: alu_value};
    lsb_in   = '{rob_id: lsb_rob_id, value: lsb_value};
    alu_push = normal && alu_valid && !alu_full;
    lsb_push = normal && lsb_valid && !lsb_full;
    drop     = normal && ((alu_valid && alu_full) || (lsb_valid && lsb_full));
  end

  // Round-robin grant on the current FIFO heads.
  always_comb begin
    grant_any   = 1'b0;
    grant_src   = SRC_ALU;
    grant_entry = alu_head;
    if (!alu_empty && !lsb_empty) begin
      grant_any = 1'b1;
      grant_src = ~rr_last;
    end else if (!alu_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_ALU;
    end else if (!lsb_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_LSB;
    end
    if (grant_src == SRC_LSB) begin
      grant_entry = lsb_head;
    end
    alu_pop = normal && grant_any && (grant_src == SRC_ALU);
    lsb_pop = normal && grant_any && (grant_src == SRC_LSB);
  end

  cdb_arbiter_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .wdata (alu_in),
    .rdata (alu_head),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_arbiter_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .wdata (lsb_in),
    .rdata (lsb_head),
    .empty (lsb_empty),
    .full  (lsb_full)
  );

  // Registered broadcast bus and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= SRC_ALU;
      rr_last    <= SRC_LSB;
    end else if (flush) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      rr_last    <= SRC_LSB;
    end else if (rdy) begin
      if (grant_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= grant_entry.rob_id;
        cdb_value  <= grant_entry.value;
        cdb_src    <= grant_src;
        rr_last    <= grant_src;
      end else begin
        cdb_valid  <= 1'b0;
        cdb_rob_id <= '0;
        cdb_value  <= '0;
      end
    end
  end

  // Sticky drop indicator; survives clear, only reset removes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model
// compared every cycle, plus directed literal checks.

module tb_cdb_arbiter;

  localparam int unsigned ROB_ID_W = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DATA_W   = 32;

  logic                clk;
  logic                rst;
  logic                rdy;
  logic                clear;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_value;
  logic                alu_full;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [DATA_W-1:0]   lsb_value;
  logic                lsb_full;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_value;
  logic                cdb_src;
  logic                overflow;

  cdb_arbiter #(
    .ROB_ID_W (ROB_ID_W),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_full   (alu_full),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_full   (lsb_full),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_ID_W-1:0] id;
    logic [DATA_W-1:0]   v;
  } ent_t;

  ent_t qa[$];
  ent_t ql[$];
  logic                m_valid;
  logic [ROB_ID_W-1:0] m_id;
  logic [DATA_W-1:0]   m_val;
  logic                m_src;
  logic                m_ovf;
  int                  m_rr;

  int n_tests = 0;
  int n_fail  = 0;
  int log_id[$];
  int log_src[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge applied to the queues.
  task automatic model_edge();
    int na;
    int nl;
    int g;
    ent_t e;
    na = qa.size();
    nl = ql.size();
    if (rst) begin
      qa.delete(); ql.delete();
      m_valid = 0; m_id = '0; m_val = '0; m_src = 0; m_ovf = 0; m_rr = 1;
    end else if (clear && rdy) begin
      qa.delete(); ql.delete();
      m_valid = 0; m_id = '0; m_val = '0; m_rr = 1;
    end else if (rdy) begin
      g = -1;
      if (na > 0 && nl > 0) g = (m_rr == 1) ? 0 : 1;
      else if (na > 0)      g = 0;
      else if (nl > 0)      g = 1;
      if (g == 0) begin
        e = qa.pop_front();
        m_valid = 1; m_id = e.id; m_val = e.v; m_src = 0; m_rr = 0;
      end else if (g == 1) begin
        e = ql.pop_front();
        m_valid = 1; m_id = e.id; m_val = e.v; m_src = 1; m_rr = 1;
      end else begin
        m_valid = 0; m_id = '0; m_val = '0;
      end
      if (alu_valid) begin
        if (na == DEPTH) m_ovf = 1;
        else begin e.id = alu_rob_id; e.v = alu_value; qa.push_back(e); end
      end
      if (lsb_valid) begin
        if (nl == DEPTH) m_ovf = 1;
        else begin e.id = lsb_rob_id; e.v = lsb_value; ql.push_back(e); end
      end
    end
  endtask

  // One cycle: edge, model update, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
    chk("cdb_value", 64'(cdb_value), 64'(m_val));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("alu_full", 64'(alu_full), 64'(qa.size() == DEPTH));
    chk("lsb_full", 64'(lsb_full), 64'(ql.size() == DEPTH));
    if (cdb_valid) begin
      log_id.push_back(int'(cdb_rob_id));
      log_src.push_back(int'(cdb_src));
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clear = 0;
    alu_valid = 0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 0; lsb_rob_id = '0; lsb_value = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
    log_id.delete();
    log_src.delete();
  endtask

  task automatic drive_alu(input int id, input int v);
    alu_valid = 1; alu_rob_id = ROB_ID_W'(id); alu_value = DATA_W'(v);
  endtask

  task automatic drive_lsb(input int id, input int v);
    lsb_valid = 1; lsb_rob_id = ROB_ID_W'(id); lsb_value = DATA_W'(v);
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_full", 64'({alu_full, lsb_full}), 64'd0);

    // Single uncontended ALU result: visible two cycles after input.
    do_reset();
    drive_alu(3, 'h11);
    step();
    idle();
    step();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_id", 64'(cdb_rob_id), 64'd3);
    chk("t1_value", 64'(cdb_value), 64'h11);
    chk("t1_src", 64'(cdb_src), 64'd0);
    step();
    chk("t1_gone", 64'(cdb_valid), 64'd0);

    // Round-robin alternation under contention.
    do_reset();
    drive_alu(1, 'hA); drive_lsb(2, 'hB);
    step();
    drive_alu(5, 'hC); drive_lsb(6, 'hD);
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    chk("t2_count", 64'(log_id.size()), 64'd4);
    if (log_id.size() == 4) begin
      chk("t2_id0", 64'(log_id[0]), 64'd1); chk("t2_src0", 64'(log_src[0]), 64'd0);
      chk("t2_id1", 64'(log_id[1]), 64'd2); chk("t2_src1", 64'(log_src[1]), 64'd1);
      chk("t2_id2", 64'(log_id[2]), 64'd5); chk("t2_src2", 64'(log_src[2]), 64'd0);
      chk("t2_id3", 64'(log_id[3]), 64'd6); chk("t2_src3", 64'(log_src[3]), 64'd1);
    end

    // LSB alone never fills: drained as fast as it arrives.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_lsb(i, 'h100 + i);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("t3_ovf", 64'(overflow), 64'd0);
    chk("t3_count", 64'(log_id.size()), 64'd5);
    for (int i = 0; i < log_id.size(); i++) begin
      chk("t3_order", 64'(log_id[i]), 64'(i + 1));
    end

    // Both sources streaming: LSB fills at half drain rate, 7th push drops.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_alu(i, 'h200 + i); drive_lsb(i + 8, 'h300 + i);
      step();
    end
    chk("t3b_ovf_before", 64'(overflow), 64'd0);
    chk("t3b_lsb_full", 64'(lsb_full), 64'd1);
    drive_alu(6, 'h206); drive_lsb(14, 'h306);
    step();
    chk("t3b_ovf_after", 64'(overflow), 64'd1);

    // Reset during traffic with overflow set.
    drive_alu(7, 'h207); drive_lsb(15, 'h307);
    rst = 1;
    step();
    chk("t6_valid", 64'(cdb_valid), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_bus", 64'({cdb_rob_id, cdb_value, cdb_src}), 64'd0);
    chk("t6_full", 64'({alu_full, lsb_full}), 64'd0);
    idle();

    // Clear flushes pending results and drops the clear-cycle input.
    do_reset();
    drive_alu(1, 'h1); drive_lsb(2, 'h2); step();
    drive_alu(3, 'h3); drive_lsb(4, 'h4); step();
    drive_alu(5, 'h5); step();
    drive_alu(8, 'h8); clear = 1;
    step();
    idle();
    chk("t4_valid", 64'(cdb_valid), 64'd0);
    chk("t4_full", 64'(alu_full), 64'd0);
    log_id.delete();
    for (int i = 0; i < 3; i++) step();
    chk("t4_silent", 64'(log_id.size()), 64'd0);
    drive_alu(9, 'h99); step();
    idle(); step();
    chk("t4_fresh_valid", 64'(cdb_valid), 64'd1);
    chk("t4_fresh_id", 64'(cdb_rob_id), 64'd9);

    // rdy low freezes everything, including clear and inputs.
    do_reset();
    drive_alu(4, 'h44); drive_lsb(7, 'h77); step();
    idle(); step();
    chk("t5_first", 64'(cdb_rob_id), 64'd4);
    for (int i = 0; i < 3; i++) begin
      rdy = 0;
      alu_valid = i[0]; alu_rob_id = 4'hE; lsb_valid = ~i[0]; lsb_rob_id = 4'hF;
      clear = (i == 1);
      step();
      chk("t5_hold_valid", 64'(cdb_valid), 64'd1);
      chk("t5_hold_id", 64'(cdb_rob_id), 64'd4);
    end
    idle(); step();
    chk("t5_resume_id", 64'(cdb_rob_id), 64'd7);
    chk("t5_resume_src", 64'(cdb_src), 64'd1);
    step();
    chk("t5_drained", 64'(cdb_valid), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      alu_valid = ($urandom_range(0, 9) < 6);
      lsb_valid = ($urandom_range(0, 9) < 5);
      alu_rob_id = ROB_ID_W'($urandom);
      lsb_rob_id = ROB_ID_W'($urandom);
      alu_value  = $urandom;
      lsb_value  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
